// File: rtl/pattern_gen_pkg.sv
// -----------------------------------------------------------------------------
// pattern_gen_pkg
// Shared constants for the multi-pattern video test source:
//   - pattern mode encodings carried on mode_sel / mode_active
//   - ramp band identifiers for mode 0
//   - 8-entry colour-bar table and border colour, stored as one bit per
//     channel {r,g,b}; each bit is replicated to a full-scale COLOR_W channel
//     by the user, so the table serves any channel width.
// -----------------------------------------------------------------------------
package pattern_gen_pkg;

  localparam logic [2:0] MODE_RAMP    = 3'd0;
  localparam logic [2:0] MODE_BARS    = 3'd1;
  localparam logic [2:0] MODE_CHECKER = 3'd2;
  localparam logic [2:0] MODE_SOLID   = 3'd3;

  // Horizontal bands of the ramp pattern, top to bottom.
  typedef enum logic [1:0] {
    BAND_RED   = 2'd0,
    BAND_GREEN = 2'd1,
    BAND_BLUE  = 2'd2,
    BAND_GRAY  = 2'd3
  } band_e;

  localparam logic [2:0] BAR_IDX_LAST = 3'd7;

  // Packed array: the first element in the concatenation is index 7.
  // idx 0..7 = white, yellow, cyan, green, magenta, red, blue, black.
  localparam logic [7:0][2:0] BAR_RGB3 = {
    3'b000,  // 7 black
    3'b001,  // 6 blue
    3'b100,  // 5 red
    3'b101,  // 4 magenta
    3'b010,  // 3 green
    3'b011,  // 2 cyan
    3'b110,  // 1 yellow
    3'b111   // 0 white
  };

  localparam logic [2:0] BORDER_RGB3 = 3'b111;

  function automatic logic [2:0] bar_rgb3(input logic [2:0] idx);
    return BAR_RGB3[idx];
  endfunction

  // Only the generated patterns get the white frame; solid fill and the
  // reserved modes do not.
  function automatic logic mode_has_border(input logic [2:0] mode);
    return (mode == MODE_RAMP) || (mode == MODE_BARS) || (mode == MODE_CHECKER);
  endfunction

endpackage

// File: rtl/pattern_gen_mp_frame_sync_ctl.sv
// -----------------------------------------------------------------------------
// frame_sync_ctl
// Frame-synchronous control for pattern_gen_mp. Detects the falling edge of
// the active-low vsync (frame start) and, on that cycle only, latches the
// requested mode, advances the scroll offset and counts the frame.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_vs             vsync, active low
//   i_mode_sel       requested pattern mode
//   i_scroll_en      advance the offset by SCROLL_STEP at each frame start
//   o_mode           mode in effect for the current frame
//   o_offset         horizontal scroll offset (wraps modulo 2**COORD_W)
//   o_frame_cnt      frame starts since reset (wraps)
// -----------------------------------------------------------------------------
module frame_sync_ctl
  import pattern_gen_pkg::*;
#(
  parameter int COORD_W     = 12,
  parameter int SCROLL_STEP = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_vs,
  input  logic [2:0]         i_mode_sel,
  input  logic               i_scroll_en,
  output logic [2:0]         o_mode,
  output logic [COORD_W-1:0] o_offset,
  output logic [15:0]        o_frame_cnt
);

  localparam logic [COORD_W-1:0] STEP = COORD_W'(SCROLL_STEP);

  logic               r_vs_d;
  logic [2:0]         r_mode;
  logic [COORD_W-1:0] r_offset;
  logic [15:0]        r_frame_cnt;
  logic               w_fs;

  // vs_d resets high so a vsync that is already low at release counts as a
  // frame start.
  assign w_fs = r_vs_d & ~i_vs;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vs_d      <= 1'b1;
      r_mode      <= MODE_RAMP;
      r_offset    <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_d <= i_vs;
      if (w_fs) begin
        r_mode      <= i_mode_sel;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        if (i_scroll_en) begin
          r_offset <= r_offset + STEP;
        end
      end
    end
  end

  assign o_mode      = r_mode;
  assign o_offset    = r_offset;
  assign o_frame_cnt = r_frame_cnt;

endmodule

// File: rtl/pattern_gen_mp.sv
// -----------------------------------------------------------------------------
// pattern_gen_mp
// Multi-pattern video test source placed between the timing generator and the
// video output. Patterns: ramp bands, 8 colour bars, checkerboard, solid fill.
// Mode changes take effect at frame start; ramp and checker scroll per frame.
// Ports:
//   pixel_clk, reset_n          clock, asynchronous active-low reset
//   pixel_de/hs/vs              input timing (vs active low)
//   pixel_x/pixel_y             active column/row
//   image_width/image_height    active size
//   mode_sel, scroll_en         pattern request, scroll enable
//   solid_rgb                   {r,g,b} fill colour for the solid mode
//   gen_de/hs/vs                timing delayed by 2 cycles
//   gen_r/g/b                   pixel colour aligned with gen_de
//   mode_active, frame_cnt      current mode, frame starts since reset
// -----------------------------------------------------------------------------
module pattern_gen_mp
  import pattern_gen_pkg::*;
#(
  parameter int COLOR_W      = 8,
  parameter int COORD_W      = 12,
  parameter int CHECKER_LOG2 = 5,
  parameter int SCROLL_STEP  = 1
) (
  input  logic                 pixel_clk,
  input  logic                 reset_n,
  input  logic                 pixel_de,
  input  logic                 pixel_hs,
  input  logic                 pixel_vs,
  input  logic [COORD_W-1:0]   pixel_x,
  input  logic [COORD_W-1:0]   pixel_y,
  input  logic [COORD_W-1:0]   image_width,
  input  logic [COORD_W-1:0]   image_height,
  input  logic [2:0]           mode_sel,
  input  logic                 scroll_en,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic                 gen_de,
  output logic                 gen_hs,
  output logic                 gen_vs,
  output logic [COLOR_W-1:0]   gen_r,
  output logic [COLOR_W-1:0]   gen_g,
  output logic [COLOR_W-1:0]   gen_b,
  output logic [2:0]           mode_active,
  output logic [15:0]          frame_cnt
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic [COORD_W-1:0] w_offset;

  frame_sync_ctl #(
    .COORD_W     (COORD_W),
    .SCROLL_STEP (SCROLL_STEP)
  ) u_frame_sync_ctl (
    .i_clk       (pixel_clk),
    .i_rst_n     (reset_n),
    .i_vs        (pixel_vs),
    .i_mode_sel  (mode_sel),
    .i_scroll_en (scroll_en),
    .o_mode      (mode_active),
    .o_offset    (w_offset),
    .o_frame_cnt (frame_cnt)
  );

  // ---------------------------------------------------------------------------
  // Colour-bar position counters. Bars are counted per de pixel rather than
  // derived from pixel_x so they stay unscrolled and need no divider.
  // ---------------------------------------------------------------------------
  logic               r_de_d;
  logic [COORD_W-1:0] r_bar_pos;
  logic [2:0]         r_bar_idx;
  logic [COORD_W-1:0] w_bar_w;
  logic [COORD_W-1:0] w_cur_pos;
  logic [2:0]         w_cur_idx;
  logic               w_bar_wrap;

  always_comb begin
    w_bar_w = image_width >> 3;
    if (w_bar_w == '0) begin
      w_bar_w = ONE;
    end
    // The first de pixel of a line restarts at bar 0 regardless of history.
    if (pixel_de && !r_de_d) begin
      w_cur_pos = '0;
      w_cur_idx = '0;
    end else begin
      w_cur_pos = r_bar_pos;
      w_cur_idx = r_bar_idx;
    end
    w_bar_wrap = (w_cur_pos + ONE) == w_bar_w;
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_de_d    <= 1'b0;
      r_bar_pos <= '0;
      r_bar_idx <= '0;
    end else begin
      r_de_d <= pixel_de;
      if (pixel_de) begin
        if (w_bar_wrap) begin
          r_bar_pos <= '0;
          // Saturate on the black bar so any width remainder stays black.
          r_bar_idx <= (w_cur_idx == BAR_IDX_LAST) ? BAR_IDX_LAST : w_cur_idx + 3'd1;
        end else begin
          r_bar_pos <= w_cur_pos + ONE;
          r_bar_idx <= w_cur_idx;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: timing, scrolled coordinate features, region flags, bar index.
  // ---------------------------------------------------------------------------
  logic [COORD_W:0]   w_q1;
  logic [COORD_W:0]   w_half;
  logic [COORD_W:0]   w_q3;
  band_e              w_band;
  logic               w_border;
  logic [COLOR_W-1:0] w_ramp;
  logic               w_check;

  always_comb begin
    w_q1   = {1'b0, image_height >> 2};
    w_half = {1'b0, image_height >> 1};
    w_q3   = w_q1 + w_half;
    if ({1'b0, pixel_y} < w_q1) begin
      w_band = BAND_RED;
    end else if ({1'b0, pixel_y} < w_half) begin
      w_band = BAND_GREEN;
    end else if ({1'b0, pixel_y} < w_q3) begin
      w_band = BAND_BLUE;
    end else begin
      w_band = BAND_GRAY;
    end
    // Border uses the raw (unscrolled) coordinates.
    w_border = (pixel_x == '0) || ((pixel_x + ONE) == image_width) ||
               (pixel_y == '0) || ((pixel_y + ONE) == image_height);
    // The cast keeps the sum at COORD_W bits, giving the modulo wrap.
    w_ramp  = COLOR_W'(pixel_x + w_offset);
    w_check = 1'((pixel_x + w_offset) >> CHECKER_LOG2) ^ pixel_y[CHECKER_LOG2];
  end

  logic                 r_s1_de;
  logic                 r_s1_hs;
  logic                 r_s1_vs;
  logic [2:0]           r_s1_mode;
  band_e                r_s1_band;
  logic                 r_s1_border;
  logic [COLOR_W-1:0]   r_s1_ramp;
  logic                 r_s1_check;
  logic [2:0]           r_s1_bar_idx;
  logic [3*COLOR_W-1:0] r_s1_solid;

  // mode_active is sampled here, so a frame start coinciding with de only
  // affects the next capture.
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_de      <= 1'b0;
      r_s1_hs      <= 1'b1;
      r_s1_vs      <= 1'b1;
      r_s1_mode    <= MODE_RAMP;
      r_s1_band    <= BAND_RED;
      r_s1_border  <= 1'b0;
      r_s1_ramp    <= '0;
      r_s1_check   <= 1'b0;
      r_s1_bar_idx <= '0;
      r_s1_solid   <= '0;
    end else begin
      r_s1_de      <= pixel_de;
      r_s1_hs      <= pixel_hs;
      r_s1_vs      <= pixel_vs;
      r_s1_mode    <= mode_active;
      r_s1_band    <= w_band;
      r_s1_border  <= w_border;
      r_s1_ramp    <= w_ramp;
      r_s1_check   <= w_check;
      r_s1_bar_idx <= w_cur_idx;
      r_s1_solid   <= solid_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: colour mux. Channel index 2 = red, 1 = green, 0 = blue.
  // ---------------------------------------------------------------------------
  logic [2:0][COLOR_W-1:0] w_rgb_next;
  logic [2:0]              w_bar3;

  always_comb begin
    w_rgb_next = '0;
    w_bar3     = bar_rgb3(r_s1_bar_idx);
    if (r_s1_de) begin
      if (mode_has_border(r_s1_mode) && r_s1_border) begin
        for (int ch = 0; ch < 3; ch++) begin
          w_rgb_next[ch] = {COLOR_W{BORDER_RGB3[ch]}};
        end
      end else begin
        case (r_s1_mode)
          MODE_RAMP: begin
            case (r_s1_band)
              BAND_RED:   w_rgb_next[2] = r_s1_ramp;
              BAND_GREEN: w_rgb_next[1] = r_s1_ramp;
              BAND_BLUE:  w_rgb_next[0] = r_s1_ramp;
              default: begin
                w_rgb_next[2] = r_s1_ramp;
                w_rgb_next[1] = r_s1_ramp;
                w_rgb_next[0] = r_s1_ramp;
              end
            endcase
          end
          MODE_BARS: begin
            for (int ch = 0; ch < 3; ch++) begin
              w_rgb_next[ch] = {COLOR_W{w_bar3[ch]}};
            end
          end
          MODE_CHECKER: begin
            for (int ch = 0; ch < 3; ch++) begin
              w_rgb_next[ch] = {COLOR_W{r_s1_check}};
            end
          end
          MODE_SOLID: w_rgb_next = r_s1_solid;
          default:    w_rgb_next = '0;
        endcase
      end
    end
  end

  logic [COLOR_W-1:0] r_rgb [3];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_rgb[gi] <= '0;
        end else begin
          r_rgb[gi] <= w_rgb_next[gi];
        end
      end
    end
  endgenerate

  logic r_gen_de;
  logic r_gen_hs;
  logic r_gen_vs;

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_gen_de <= 1'b0;
      r_gen_hs <= 1'b1;
      r_gen_vs <= 1'b1;
    end else begin
      r_gen_de <= r_s1_de;
      r_gen_hs <= r_s1_hs;
      r_gen_vs <= r_s1_vs;
    end
  end

  assign gen_de = r_gen_de;
  assign gen_hs = r_gen_hs;
  assign gen_vs = r_gen_vs;
  assign gen_r  = r_rgb[2];
  assign gen_g  = r_rgb[1];
  assign gen_b  = r_rgb[0];

endmodule

// File: tb/tb_pattern_gen_mp.sv
// -----------------------------------------------------------------------------
// tb_pattern_gen_mp
// Drives pattern_gen_mp with directed pixels and randomized small frames. A
// behavioural model computes each pixel's expected colour from the pattern
// rules and queues it; a compare process checks every output cycle against
// that queue. Directed pixels are also checked against literal colours.
// -----------------------------------------------------------------------------
module tb_pattern_gen_mp;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b1;
  logic        pixel_de  = 1'b0;
  logic        pixel_hs  = 1'b1;
  logic        pixel_vs  = 1'b1;
  logic [11:0] pixel_x   = '0;
  logic [11:0] pixel_y   = '0;
  logic [11:0] image_width  = 12'd640;
  logic [11:0] image_height = 12'd480;
  logic [2:0]  mode_sel  = 3'd0;
  logic        scroll_en = 1'b0;
  logic [23:0] solid_rgb = '0;
  logic        gen_de, gen_hs, gen_vs;
  logic [7:0]  gen_r, gen_g, gen_b;
  logic [2:0]  mode_active;
  logic [15:0] frame_cnt;

  always #5 pixel_clk = ~pixel_clk;

  pattern_gen_mp #(
    .COLOR_W(8), .COORD_W(12), .CHECKER_LOG2(5), .SCROLL_STEP(1)
  ) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .pixel_de(pixel_de), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .image_width(image_width), .image_height(image_height),
    .mode_sel(mode_sel), .scroll_en(scroll_en), .solid_rgb(solid_rgb),
    .gen_de(gen_de), .gen_hs(gen_hs), .gen_vs(gen_vs),
    .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b),
    .mode_active(mode_active), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic        de, hs, vs;
    logic [23:0] rgb;
    logic [2:0]  mode;
    logic [15:0] fc;
    bit          cap;
    logic [11:0] x;
  } exp_t;

  exp_t        q[$];
  logic [23:0] cap_rgb [0:4095];
  int          total = 0;
  int          bad   = 0;

  // Model state, updated in input order.
  logic [2:0]  m_mode;
  logic [15:0] m_fc;
  logic [11:0] m_off;
  logic        m_vs_prev, m_de_prev;
  int          m_run;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 3'd0; m_fc = '0; m_off = '0;
    m_vs_prev = 1'b1; m_de_prev = 1'b0; m_run = 0;
    q.delete();
  endtask

  function automatic logic [23:0] bar_colour(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Record the expected output for the inputs currently driven, then clock.
  task automatic cyc(input bit cap);
    exp_t        e;
    logic [23:0] rgb;
    logic [11:0] xe, xp1, yp1;
    logic [7:0]  rv;
    int          bw, idx, q1, h2;
    bit          border;
    if (pixel_de) m_run = m_de_prev ? m_run + 1 : 0;
    bw = int'(image_width) / 8;
    if (bw == 0) bw = 1;
    idx = m_run / bw;
    if (idx > 7) idx = 7;
    xe  = pixel_x + m_off;
    rv  = xe[7:0];
    xp1 = pixel_x + 12'd1;
    yp1 = pixel_y + 12'd1;
    border = (pixel_x == 12'd0) || (xp1 == image_width) ||
             (pixel_y == 12'd0) || (yp1 == image_height);
    q1 = int'(image_height) / 4;
    h2 = int'(image_height) / 2;
    rgb = '0;
    if (pixel_de) begin
      if (m_mode < 3'd3 && border) rgb = 24'hFFFFFF;
      else begin
        case (m_mode)
          3'd0: begin
            if (int'(pixel_y) < q1)           rgb = {rv, 16'h0};
            else if (int'(pixel_y) < h2)      rgb = {8'h0, rv, 8'h0};
            else if (int'(pixel_y) < q1 + h2) rgb = {16'h0, rv};
            else                              rgb = {rv, rv, rv};
          end
          3'd1: rgb = bar_colour(idx);
          3'd2: rgb = (xe[5] ^ pixel_y[5]) ? 24'hFFFFFF : 24'h0;
          3'd3: rgb = solid_rgb;
          default: rgb = 24'h0;
        endcase
      end
    end
    if (m_vs_prev && !pixel_vs) begin
      m_mode = mode_sel;
      m_fc   = m_fc + 16'd1;
      if (scroll_en) m_off = m_off + 12'd1;
    end
    m_vs_prev = pixel_vs;
    m_de_prev = pixel_de;
    e.de = pixel_de; e.hs = pixel_hs; e.vs = pixel_vs; e.rgb = rgb;
    e.mode = m_mode; e.fc = m_fc; e.cap = cap; e.x = pixel_x;
    q.push_back(e);
    @(posedge pixel_clk);
    #1;
  endtask

  // Outputs for entry s are valid after the second edge following it; the
  // control outputs at that point reflect entry s+1.
  task automatic compare_cycle();
    exp_t e;
    if (reset_n && q.size() == 3) begin
      e = q.pop_front();
      chk("pixel", 64'({gen_de, gen_hs, gen_vs, gen_r, gen_g, gen_b}),
                   64'({e.de, e.hs, e.vs, e.rgb}));
      if (e.cap) cap_rgb[e.x] = {gen_r, gen_g, gen_b};
      chk("ctl", 64'({mode_active, frame_cnt}), 64'({q[0].mode, q[0].fc}));
    end
  endtask

  task automatic vs_pulse();
    pixel_vs = 1'b0; cyc(0);
    pixel_vs = 1'b1; cyc(0);
  endtask

  task automatic poke(input logic [11:0] x, input logic [11:0] y, input logic de);
    pixel_de = de; pixel_x = x; pixel_y = y; cyc(1);
    pixel_de = 1'b0; cyc(0); cyc(0); cyc(0);
  endtask

  task automatic line(input int w, input logic [11:0] y);
    pixel_de = 1'b0;
    for (int b = 0; b < 4; b++) cyc(0);
    for (int px = 0; px < w; px++) begin
      pixel_de = 1'b1; pixel_x = 12'(px); pixel_y = y; cyc(1);
    end
    pixel_de = 1'b0;
    for (int b = 0; b < 4; b++) cyc(0);
  endtask

  initial begin
    int w, h;
    bit fsde;
    fork
      forever begin
        @(negedge pixel_clk);
        compare_cycle();
      end
    join_none

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    chk("reset_state", 64'({gen_de, gen_hs, gen_vs, gen_r, gen_g, gen_b, mode_active, frame_cnt}),
        64'({1'b0, 1'b1, 1'b1, 24'h0, 3'd0, 16'd0}));
    repeat (3) @(posedge pixel_clk);
    #1 reset_n = 1'b1;
    model_reset();

    // Ramp bands on 640x480 and two-cycle latency
    vs_pulse();
    chk("fc_first", 64'(frame_cnt), 64'd1);
    cyc(0); cyc(0);
    pixel_de = 1'b1; pixel_x = 12'd100; pixel_y = 12'd60; cyc(0);
    chk("lat_1cyc_de", 64'(gen_de), 64'd0);
    pixel_de = 1'b0; cyc(0);
    chk("lat_2cyc", 64'({gen_de, gen_r, gen_g, gen_b}), 64'({1'b1, 24'h640000}));
    cyc(0); cyc(0);
    poke(12'd100, 12'd60, 1'b1);  chk("ramp_red",   64'(cap_rgb[100]), 64'h640000);
    poke(12'd100, 12'd200, 1'b1); chk("ramp_green", 64'(cap_rgb[100]), 64'h006400);
    poke(12'd100, 12'd300, 1'b1); chk("ramp_blue",  64'(cap_rgb[100]), 64'h000064);
    poke(12'd100, 12'd400, 1'b1); chk("ramp_gray",  64'(cap_rgb[100]), 64'h646464);
    poke(12'd0, 12'd250, 1'b1);   chk("border_l",   64'(cap_rgb[0]),   64'hFFFFFF);
    poke(12'd639, 12'd250, 1'b1); chk("border_r",   64'(cap_rgb[639]), 64'hFFFFFF);

    // Mid-frame mode request waits for the next frame start
    mode_sel = 3'd2;
    poke(12'd32, 12'd1, 1'b1);    chk("no_tear", 64'(cap_rgb[32]), 64'h200000);
    chk("mode_hold", 64'(mode_active), 64'd0);
    vs_pulse();
    chk("mode_switch", 64'({mode_active, frame_cnt}), 64'({3'd2, 16'd2}));
    poke(12'd32, 12'd1, 1'b1);    chk("chk_white", 64'(cap_rgb[32]), 64'hFFFFFF);
    poke(12'd32, 12'd32, 1'b1);   chk("chk_black", 64'(cap_rgb[32]), 64'h000000);

    // Colour bars, widths 640 and 645
    mode_sel = 3'd1;
    vs_pulse();
    line(640, 12'd100);
    chk("bar_x0",   64'(cap_rgb[0]),   64'hFFFFFF);
    chk("bar_x79",  64'(cap_rgb[79]),  64'hFFFFFF);
    chk("bar_x80",  64'(cap_rgb[80]),  64'hFFFF00);
    chk("bar_x160", 64'(cap_rgb[160]), 64'h00FFFF);
    chk("bar_x560", 64'(cap_rgb[560]), 64'h000000);
    image_width = 12'd645;
    line(645, 12'd100);
    chk("bar645_x559", 64'(cap_rgb[559]), 64'h0000FF);
    chk("bar645_x643", 64'(cap_rgb[643]), 64'h000000);
    chk("bar645_x644", 64'(cap_rgb[644]), 64'hFFFFFF);
    image_width = 12'd640;

    // Solid fill, de gating, reserved mode
    mode_sel = 3'd3; solid_rgb = 24'h123456;
    vs_pulse();
    poke(12'd0, 12'd0, 1'b1);     chk("solid_corner", 64'(cap_rgb[0]),   64'h123456);
    poke(12'd300, 12'd300, 1'b1); chk("solid_mid",    64'(cap_rgb[300]), 64'h123456);
    poke(12'd300, 12'd300, 1'b0); chk("de_low_black", 64'(cap_rgb[300]), 64'h000000);
    mode_sel = 3'd5;
    vs_pulse();
    poke(12'd300, 12'd300, 1'b1); chk("mode5_black", 64'(cap_rgb[300]), 64'h000000);
    chk("mode5_active", 64'(mode_active), 64'd5);

    // Asynchronous reset in the middle of a line
    mode_sel = 3'd0;
    vs_pulse();
    for (int i = 5; i < 10; i++) begin
      pixel_de = 1'b1; pixel_x = 12'(i); pixel_y = 12'd50; cyc(0);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("reset_midline", 64'({gen_de, gen_hs, gen_vs, gen_r, gen_g, gen_b, mode_active, frame_cnt}),
        64'({1'b0, 1'b1, 1'b1, 24'h0, 3'd0, 16'd0}));
    model_reset();
    @(posedge pixel_clk);
    #1;
    pixel_de = 1'b0; reset_n = 1'b1;
    cyc(0);
    vs_pulse();
    chk("fc_after_reset", 64'(frame_cnt), 64'd1);

    // Scroll, including the offset wrap 4095 -> 0
    scroll_en = 1'b1;
    for (int i = 0; i < 3; i++) vs_pulse();
    poke(12'd10, 12'd60, 1'b1);   chk("scroll_3", 64'(cap_rgb[10]), 64'h0D0000);
    for (int i = 0; i < 4092; i++) vs_pulse();
    poke(12'd10, 12'd60, 1'b1);   chk("scroll_4095", 64'(cap_rgb[10]), 64'h090000);
    chk("fc_4096", 64'(frame_cnt), 64'd4096);
    vs_pulse();
    poke(12'd10, 12'd60, 1'b1);   chk("scroll_wrap", 64'(cap_rgb[10]), 64'h0A0000);

    // Randomized small frames, mode requests changing every line
    for (int f = 0; f < 25; f++) begin
      w = $urandom_range(2, 40);
      h = $urandom_range(4, 12);
      fsde = ($urandom_range(0, 3) == 0);
      image_width  = 12'(w);
      image_height = 12'(h);
      scroll_en = 1'($urandom_range(0, 1));
      solid_rgb = 24'($urandom);
      mode_sel  = 3'($urandom_range(0, 7));
      if (!fsde) begin
        pixel_vs = 1'b0; cyc(0); cyc(0); pixel_vs = 1'b1;
      end
      for (int ln = 0; ln < h; ln++) begin
        mode_sel = 3'($urandom_range(0, 7));
        for (int b = 0; b < 4; b++) begin
          pixel_de = 1'b0; pixel_hs = (b < 2) ? 1'b0 : 1'b1;
          pixel_x = 12'($urandom); pixel_y = 12'($urandom);
          cyc(0);
        end
        for (int px = 0; px < w; px++) begin
          pixel_de = 1'b1; pixel_x = 12'(px); pixel_y = 12'(ln);
          if (fsde && ln == 0) pixel_vs = (px < 2) ? 1'b0 : 1'b1;
          cyc(0);
        end
        pixel_de = 1'b0; pixel_vs = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
